branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/btb_pkg.sv | 26 ++
 rtl/btb_lru.sv | 51 +++++
 rtl/branch_target_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: 2-bit direction
// counter encoding and its saturating update.
package btb_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;
  localparam bp_ctr_t BP_CTR_ALLOC = WT;

  function automatic bp_ctr_t sat_step(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    nxt = ctr;
    if (taken && (ctr != ST)) begin
      nxt = bp_ctr_t'(ctr + 2'd1);
    end else if (!taken && (ctr != SNT)) begin
      nxt = bp_ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_lru.sv
// True-LRU helper for one set: ages the set around a touched way and picks
// the replacement victim (lowest invalid way first, else the oldest way).
module btb_lru
  import btb_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages_i,
  input  logic [AGE_W-1:0]           touch_i,
  input  logic [WAYS-1:0]            valid_i,
  output logic [WAYS-1:0][AGE_W-1:0] ages_o,
  output logic [AGE_W-1:0]           victim_o
);

  logic [AGE_W-1:0] touch_age;
  logic             found;

  assign touch_age = ages_i[touch_i];

  always_comb begin
    ages_o = ages_i;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch_i) begin
        ages_o[w] = '0;
      end else if (ages_i[w] < touch_age) begin
        ages_o[w] = ages_i[w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_i[w]) begin
        victim_o = AGE_W'(w);
        found    = 1'b1;
      end
    end
    // All ways valid: the way holding the maximum age is the LRU one.
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages_i[w] == AGE_W'(WAYS - 1)) begin
          victim_o = AGE_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Set-associative branch target buffer: combinational fetch-stage lookup,
// execute-stage update with 2-bit direction counters and true-LRU replacement.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WAYS = 2,
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pcF_i,
  output logic            hitF_o,
  output logic            takenF_o,
  output logic [XLEN-1:0] targetF_o,
  input  logic            updE_i,
  input  logic [XLEN-1:0] pcE_i,
  input  logic            takenE_i,
  input  logic [XLEN-1:0] targetE_i
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - 2 - IDX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]            valid_q  [SETS];
  logic [TAG_W-1:0]           tag_q    [SETS][WAYS];
  logic [XLEN-1:0]            target_q [SETS][WAYS];
  bp_ctr_t                    ctr_q    [SETS][WAYS];
  logic [WAYS-1:0][AGE_W-1:0] age_q    [SETS];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic [AGE_W-1:0] way_f, way_e;
  logic [1:0]       ctr_f;
  logic [AGE_W-1:0] victim, touch;
  logic [WAYS-1:0][AGE_W-1:0] ages_next;
  logic             unused_pc_lo;

  assign idx_f = pcF_i[IDX_W+1:2];
  assign tag_f = pcF_i[XLEN-1:IDX_W+2];
  assign idx_e = pcE_i[IDX_W+1:2];
  assign tag_e = pcE_i[XLEN-1:IDX_W+2];
  assign unused_pc_lo = ^{pcF_i[1:0], pcE_i[1:0]};

  // Lowest matching way wins; several matches only happen on a corrupted array.
  always_comb begin
    hit_f = 1'b0;
    way_f = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_f && valid_q[idx_f][w] && (tag_q[idx_f][w] == tag_f)) begin
        hit_f = 1'b1;
        way_f = AGE_W'(w);
      end
    end
  end

  always_comb begin
    hit_e = 1'b0;
    way_e = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_e && valid_q[idx_e][w] && (tag_q[idx_e][w] == tag_e)) begin
        hit_e = 1'b1;
        way_e = AGE_W'(w);
      end
    end
  end

  assign ctr_f     = ctr_q[idx_f][way_f];
  assign hitF_o    = hit_f;
  assign takenF_o  = hit_f & ctr_f[1];
  assign targetF_o = hit_f ? target_q[idx_f][way_f] : '0;

  assign touch = hit_e ? way_e : victim;

  btb_lru #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages_i   (age_q[idx_e]),
    .touch_i  (touch),
    .valid_i  (valid_q[idx_e]),
    .ages_o   (ages_next),
    .victim_o (victim)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= BP_CTR_RESET;
          age_q[s][w]    <= AGE_W'(w);
        end
      end
    end else if (flush_i) begin
      // Only validity is lost; counters, targets and ages survive a flush.
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (updE_i) begin
      if (hit_e) begin
        ctr_q[idx_e][way_e] <= sat_step(ctr_q[idx_e][way_e], takenE_i);
        if (takenE_i) begin
          target_q[idx_e][way_e] <= targetE_i;
        end
        age_q[idx_e] <= ages_next;
      end else if (takenE_i) begin
        valid_q[idx_e][victim]  <= 1'b1;
        tag_q[idx_e][victim]    <= tag_e;
        target_q[idx_e][victim] <= targetE_i;
        ctr_q[idx_e][victim]    <= BP_CTR_ALLOC;
        age_q[idx_e]            <= ages_next;
      end
    end
  end

endmodule
